// File: rtl/radix2_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned values.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Initial,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  // Handshake: Initial is a start request honoured only in IDLE; operands are captured on
  // that edge. done pulses for one cycle when quotient/remainder/flags are updated.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;
  logic             ov_pend;

  logic               dvd_neg;
  logic               dvs_neg;
  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic               start_dz;
  logic               start_ov;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               take;

  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               range_ov;
  logic               fix_ov;
  logic               fix_err;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  assign dvd_neg = dividend[2*WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
  // Positive results must stay below 2^(WIDTH-1); negative ones may reach it exactly.
  assign range_ov = neg_q ? (lo > HALF) : lo[WIDTH-1];
`else
  assign dvd_neg  = 1'b0;
  assign dvs_neg  = 1'b0;
  assign range_ov = 1'b0;
`endif

  // Negation in the full 2*WIDTH width keeps -2^(2*WIDTH-1) representable as a magnitude.
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;
  assign start_dz = (dvs_mag == '0);
  assign start_ov = !start_dz && (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);

  // pr < dv holds every step, so a successful trial difference always fits in WIDTH bits.
  assign shifted = {pr, lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dv};
  assign take    = ~diff[WIDTH];

  assign q_fix   = neg_q ? -lo : lo;
  assign r_fix   = neg_r ? -pr : pr;
  assign fix_ov  = ov_pend | range_ov;
  assign fix_err = dz_pend | fix_ov;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pr        <= '0;
      lo        <= '0;
      dv        <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_pend   <= 1'b0;
      ov_pend   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Initial) begin
            pr       <= dvd_mag[2*WIDTH-1:WIDTH];
            lo       <= dvd_mag[WIDTH-1:0];
            dv       <= dvs_mag;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            dz_pend  <= start_dz;
            ov_pend  <= start_ov;
            count    <= CNT_INIT;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= (start_dz || start_ov) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          pr    <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          lo    <= {lo[WIDTH-2:0], take};
          count <= count - CNT_ONE;
          if (count == CNT_ONE) state <= S_FIX;
        end
        S_FIX: begin
          quotient  <= fix_err ? '0 : q_fix;
          remainder <= fix_err ? '0 : r_fix;
          div_zero  <= dz_pend;
          overflow  <= fix_ov;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/radix2_divider.md
Name: radix2_divider

Overview:
- Sequential restoring divider. It is the inverse of the multiplier block: it takes a 2*WIDTH-bit product-width dividend and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Produces one quotient bit per cycle.
- Uses the same start-pulse / fixed-latency interface style as the multipliers.
- Results are used to check multiplier outputs in-system and to support future divide datapaths.

Parameters:
- WIDTH, 32, width of divisor, quotient and remainder. The dividend is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- Initial  input  1  start request; sampled only in IDLE.
- dividend  input  2*WIDTH  numerator; sampled on the start edge.
- divisor  input  WIDTH  denominator; sampled on the start edge.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; quotient and remainder are valid.
- div_zero  output  1  sticky until the next start: divisor was 0.
- overflow  output  1  sticky until the next start: quotient does not fit in WIDTH bits.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state becomes IDLE; quotient, remainder, busy, done, div_zero and overflow all become 0.
  - This applies mid-operation: the running division is abandoned and produces no done.
- States:
  - IDLE: if Initial is high, latch operand magnitudes and signs, clear div_zero and overflow, busy=1.
    - divisor==0 -> FIX with div_zero pending.
    - else if the upper WIDTH bits of |dividend| >= |divisor| -> FIX with overflow pending.
    - else -> CALC with count=WIDTH.
  - CALC:
    - Shift the {partial remainder, dividend} register left by 1.
    - Trial-subtract |divisor| from the upper WIDTH+1 bits; if non-negative, keep the difference and set quotient bit 1, else restore and set 0.
    - Decrement count; when count reaches 0 -> FIX.
  - FIX:
    - Apply signs: quotient is negated when the operand signs differ (truncation toward zero); remainder takes the sign of the dividend.
    - Signed range check: a positive quotient must be <= 2^(WIDTH-1)-1 and a negative one <= 2^(WIDTH-1) in magnitude; otherwise set overflow.
    - Register the outputs, done=1 for exactly one cycle, busy=0, then -> IDLE.
- Error results: on div_zero or overflow, quotient=0 and remainder=0.
- Latency, normal path: start edge E; done is high in the cycle after edge E+WIDTH+1; outputs are registered at that edge.
- Latency, error path: done is high in the cycle after edge E+1.
- Start while busy: Initial is ignored; the operation in progress is unaffected.
- Initial held high: a new division begins on the edge after FIX, since that edge sees IDLE with Initial high.
- Output hold: quotient and remainder hold their values until the next FIX.
- Width rule: the dividend magnitude is computed in 2*WIDTH unsigned bits, so -2^(2*WIDTH-1) is handled.
- Reset during FIX: reset wins and done is not asserted.

Optional Feature:
- DIV_SIGNED_EN defined:
  - Operands are two's complement.
  - Sign handling and the signed range check apply as described above.
- DIV_SIGNED_EN not defined:
  - Operands are unsigned; magnitudes equal the raw inputs.
  - No sign fix-up in FIX.
  - overflow is raised only by the upper-half pre-check.
  - A quotient up to 2^WIDTH-1 is legal.

Test Plan:
- Exact division, signed build: dividend=464960160, divisor=840, one-cycle Initial -> done exactly WIDTH+2 cycles after the Initial edge; quotient=553524, remainder=0, overflow=0, div_zero=0.
- Sign cases, signed build:
  - -143362716 / -259 -> quotient=553524, remainder=0.
  - -464960163 / 840 -> quotient=-553524, remainder=-3.
  - 464960163 / -840 -> quotient=-553524, remainder=3.
- Large exact division: 1818861401553467748 / 1348543286 -> quotient=1348760118, remainder=0.
- Error cases:
  - divisor=0 with any dividend -> done 2 cycles after start; div_zero=1, quotient=0, remainder=0.
  - dividend=64'h0000_0001_0000_0000, divisor=1 -> overflow=1 after 2 cycles.
  - dividend=2^31, divisor=1 -> overflow=1 in the signed build; quotient=2147483648, overflow=0 in the unsigned build.
- Start during busy: start 100/7, re-pulse Initial with 50/5 at cycle 10 -> a single done; quotient=14, remainder=2.
- Reset mid-operation: start 100/7, drive rst_n low at cycle 15 -> all outputs 0, no done. A new start 50/5 after reset -> quotient=10, remainder=0.
